fb_swap_ctrl: RTL and testbench
===============================

Name: fb_swap_ctrl

Overview:
- Double-buffer (ping-pong) controller for the LED-matrix frame buffer.
- Accepts a raster pixel stream from the lava simulation engine and writes it into the back bank of the top/bottom half RAMs.
- Swaps front/back banks only on a display frame boundary, detected as the panel row select wrapping from last row to 0, so the display never shows a torn frame.
- Sits between the simulation engine, the two half-panel RAMs, and the display controller; the display read address is formed externally as {rd_bank, r_addr}.

Parameters:
- ADDR_W, 10, per-half RAM address width (64 columns x 16 rows = 1024 entries)
- DATA_W, 12, pixel width (RGB444)
- ROW_W, 4, width of display row select
- LAST_ROW, 15, row-select value that ends a frame

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- disp_row  in  ROW_W  current row select from display controller
- wr_valid  in  1  writer pixel valid
- wr_ready  out  1  controller can accept a pixel
- wr_data  in  DATA_W  pixel, raster order, top-half rows first
- wr_last  in  1  writer marks final pixel of frame
- ram_we_top  out  1  write enable, top-half RAM
- ram_we_btm  out  1  write enable, bottom-half RAM
- ram_waddr  out  ADDR_W+1  {wr_bank, pixel address}
- ram_wdata  out  DATA_W  registered pixel data
- rd_bank  out  1  front bank for display reads
- swap  out  1  one-cycle pulse when banks swap
- pending  out  1  back bank full, awaiting boundary
- sync_err  out  1  sticky; wr_last position mismatch

Behaviour:
- Reset (rst=0, async): state=FILL, pix_cnt=0, rd_bank=0, wr_bank=1, prev_row=0, all other outputs=0.
- wr_ready is registered; it is 0 while in reset, rises the first clk after release, and thereafter equals (state==FILL).
- Accept: wr_valid & wr_ready on a rising edge.
- pix_cnt: ADDR_W+1 bits (0..2047).
- Write path, one cycle after an accept:
  - ram_wdata=wr_data.
  - ram_waddr={wr_bank, pix_cnt[ADDR_W-1:0]}.
  - ram_we_top=~pix_cnt[ADDR_W]; ram_we_btm=pix_cnt[ADDR_W].
  - With no accept, both we outputs are 0.
- Frame boundary: a one-cycle internal pulse when prev_row==LAST_ROW and disp_row==0. prev_row updates every clk.
- FILL state:
  - Each accept increments pix_cnt.
  - Accept at pix_cnt=2047: pix_cnt wraps to 0; next state PEND; wr_ready drops on the following edge (accepts are 2048 total).
  - Accept with wr_last=1 and pix_cnt!=2047: set sync_err; pix_cnt=0; stay in FILL (resync; the partial frame is overwritten).
  - Accept at pix_cnt=2047 with wr_last=0: set sync_err; still go to PEND.
  - Boundary in FILL: ignored; the display repeats the current front frame.
- PEND state:
  - wr_ready=0, pending=1.
  - On boundary: rd_bank<=~rd_bank, wr_bank<=~wr_bank, swap=1 for one cycle, go to FILL.
- Boundary on the same cycle as the final (2048th) accept: not used for the swap; the swap waits for the next boundary.
- Swap takes effect on the edge after the boundary is detected. rd_bank must be stable while the display shifts row 0 of the new frame.
- rd_bank and wr_bank are always complementary.
- sync_err is cleared only by reset.
- Reset mid-frame: partial back-bank data is abandoned and rd_bank returns to 0. RAM contents are not cleared.

Test Plan:
- Reset release, disp_row held 0 -> wr_ready=1 one clk after release; rd_bank=0; ram_waddr MSB=1 on the first write.
- Stream pixels 0..2047 with wr_data=index and wr_last on the final pixel -> ram_we_top asserts for indices 0..1023 at addr 0..1023 and ram_we_btm for indices 1024..2047 at addr 0..1023; pending=1 and wr_ready=0 after the last pixel.
- PEND, then drive disp_row 14,15,0 -> swap pulses exactly once, one clk after disp_row=0; rd_bank=1; next write uses bank 0; wr_ready=1.
- Full frame stored, disp_row=0 coinciding with the 2048th accept -> no swap then; swap on the following 15->0 wrap.
- wr_last on pixel 100 -> sync_err=1; the next pixel writes to addr 0 of the top RAM; the controller still fills and swaps normally afterward.
- Assert rst mid-frame at pix_cnt=500 after one prior swap -> all outputs 0 immediately (async); after release rd_bank=0, the first write goes to bank 1 at addr 0.

Source files
------------

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: ping-pong frame buffer controller that swaps banks only on display frame boundaries
module fb_swap_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12,
  parameter int ROW_W = 4,
  parameter int LAST_ROW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  disp_row,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              ram_we_top,
  output logic              ram_we_btm,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              rd_bank,
  output logic              swap,
  output logic              pending,
  output logic              sync_err
);
  typedef enum logic {FILL, PEND} state_t;
  state_t state;
  logic [ADDR_W:0] pix_cnt;
  logic [ROW_W-1:0] prev_row;
  logic wr_bank;
  logic accept;
  logic boundary;
  logic full;
  // wr_ready is only high in FILL, so an accept always belongs to the fill phase
  assign accept = wr_valid & wr_ready;
  assign boundary = (prev_row == ROW_W'(LAST_ROW)) && (disp_row == '0);
  assign full = &pix_cnt;
  // fill/pend FSM with registered write port; wr_ready tracks the next state so no extra pixel sneaks in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      pix_cnt <= '0;
      prev_row <= '0;
      rd_bank <= 1'b0;
      wr_bank <= 1'b1;
      wr_ready <= 1'b0;
      ram_we_top <= 1'b0;
      ram_we_btm <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      swap <= 1'b0;
      pending <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      prev_row <= disp_row;
      swap <= 1'b0;
      ram_we_top <= accept & ~pix_cnt[ADDR_W];
      ram_we_btm <= accept & pix_cnt[ADDR_W];
      if (accept) begin
        ram_wdata <= wr_data;
        ram_waddr <= {wr_bank, pix_cnt[ADDR_W-1:0]};
      end
      if (state == FILL) begin
        wr_ready <= ~(accept & full);
        pending <= accept & full;
        if (accept) begin
          pix_cnt <= (wr_last & ~full) ? '0 : pix_cnt + 1'b1;
          if (wr_last != full) sync_err <= 1'b1;
          if (full) state <= PEND;
        end
      end else if (boundary) begin
        rd_bank <= ~rd_bank;
        wr_bank <= ~wr_bank;
        swap <= 1'b1;
        wr_ready <= 1'b1;
        pending <= 1'b0;
        state <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: directed checks of fill, swap timing, resync and async reset
module tb_fb_swap_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] disp_row;
  logic wr_valid;
  logic wr_ready;
  logic [11:0] wr_data;
  logic wr_last;
  logic ram_we_top;
  logic ram_we_btm;
  logic [10:0] ram_waddr;
  logic [11:0] ram_wdata;
  logic rd_bank;
  logic swap;
  logic pending;
  logic sync_err;
  int vectors = 0;
  int miscompares = 0;

  fb_swap_ctrl dut (
    .clk(clk), .rst(rst), .disp_row(disp_row), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .ram_we_top(ram_we_top), .ram_we_btm(ram_we_btm),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .rd_bank(rd_bank), .swap(swap),
    .pending(pending), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int first, input int last_idx, input int last_flag_idx,
                            input bit bank, input bit wrap);
    logic [11:0] d;
    for (int i = first; i <= last_idx; i++) begin
      d = i[11:0];
      wr_valid = 1'b1;
      wr_data = d;
      wr_last = (i == last_flag_idx);
      if (wrap && i == last_idx - 1) disp_row = 4'd15;
      if (wrap && i == last_idx) disp_row = 4'd0;
      tick();
      chk("write", {6'd0, wr_ready, ram_we_top, ram_we_btm, ram_waddr, ram_wdata},
          {6'd0, (i != 2047), ~d[10], d[10], bank, d[9:0], d});
    end
    wr_valid = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wrap_rows(input bit exp_rd);
    disp_row = 4'd14;
    tick();
    disp_row = 4'd15;
    tick();
    chk("no_swap_before_wrap", {31'd0, swap}, 32'd0);
    disp_row = 4'd0;
    tick();
    chk("swap_pulse", {28'd0, swap, rd_bank, wr_ready, pending}, {28'd0, 1'b1, exp_rd, 1'b1, 1'b0});
    tick();
    chk("swap_one_cycle", {31'd0, swap}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    disp_row = 4'd0;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    #12;
    chk("reset_outputs", {3'd0, wr_ready, ram_we_top, ram_we_btm, ram_waddr, ram_wdata, rd_bank, swap, pending, sync_err}, 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_low_before_edge", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("ready_after_release", {30'd0, wr_ready, rd_bank}, {30'd0, 1'b1, 1'b0});
    push_range(0, 2047, 2047, 1'b1, 1'b0);
    chk("pend_after_frame", {29'd0, pending, wr_ready, sync_err}, {29'd0, 1'b1, 1'b0, 1'b0});
    tick();
    chk("idle_no_we", {29'd0, ram_we_top, ram_we_btm, swap}, 32'd0);
    wrap_rows(1'b1);
    push_range(0, 2047, 2047, 1'b0, 1'b1);
    chk("boundary_on_last_ignored", {30'd0, swap, pending}, {30'd0, 1'b0, 1'b1});
    tick();
    chk("still_pending", {29'd0, swap, pending, rd_bank}, {29'd0, 1'b0, 1'b1, 1'b1});
    wrap_rows(1'b0);
    push_range(0, 100, 100, 1'b1, 1'b0);
    chk("sync_err_set", {30'd0, sync_err, wr_ready}, {30'd0, 1'b1, 1'b1});
    push_range(0, 2047, 2047, 1'b1, 1'b0);
    chk("resync_frame_pend", {30'd0, pending, sync_err}, {30'd0, 1'b1, 1'b1});
    wrap_rows(1'b1);
    chk("sync_err_sticky", {31'd0, sync_err}, 32'd1);
    push_range(0, 499, -1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {3'd0, wr_ready, ram_we_top, ram_we_btm, ram_waddr, ram_wdata, rd_bank, swap, pending, sync_err}, 32'd0);
    #1;
    rst = 1'b1;
    tick();
    chk("ready_after_mid_reset", {30'd0, wr_ready, rd_bank}, {30'd0, 1'b1, 1'b0});
    push_range(0, 0, -1, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
